// File: rtl/cavlc_pkg.sv
// Shared definitions for the CAVLC coefficient buffer controller.
//   DEF_WIDTH / DEF_ADDR_WIDTH : default coefficient width and BRAM address width
//   BLK_SIZE                   : coefficients per 4x4 block
//   ZZ_REV                     : raster address read at each drain step (reverse zig-zag)
//   state_t                    : controller states
package cavlc_pkg;

  localparam int DEF_WIDTH      = 9;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int BLK_SIZE       = 16;

  // Step 0 reads zig-zag position 15, step 15 reads zig-zag position 0 (DC).
  localparam logic [3:0] ZZ_REV [BLK_SIZE] = '{
    4'd15, 4'd14, 4'd11, 4'd7,  4'd10, 4'd13, 4'd12, 4'd9,
    4'd6,  4'd3,  4'd2,  4'd5,  4'd8,  4'd4,  4'd1,  4'd0
  };

  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    LAST
  } state_t;

endpackage

// File: rtl/cavlc_coeff_stats.sv
// Per-block CAVLC statistics over the reverse zig-zag output stream.
//   clk, rst      : clock, asynchronous active-low reset
//   acc           : an output coefficient is accepted this cycle
//   first         : the accepted coefficient is the first of its block
//   data          : accepted coefficient (signed two's complement)
//   total_coeff   : number of nonzero coefficients in the block (0..16)
//   trailing_ones : +/-1 values seen before the first |value|>1, saturating at 3
// Results stay valid after the last accept and are restarted by the first
// accept of the next block. Only instantiated when CAVLC_STATS_EN is defined.
module cavlc_coeff_stats
  import cavlc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic             first,
  input  logic [WIDTH-1:0] data,
  output logic [4:0]       total_coeff,
  output logic [1:0]       trailing_ones
);

  logic nz, pm1, big;
  logic big_seen;

  assign nz  = (data != '0);
  assign pm1 = (data == WIDTH'(1)) || (data == '1);
  assign big = nz && !pm1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total_coeff   <= '0;
      trailing_ones <= '0;
      big_seen      <= 1'b0;
    end else if (acc) begin
      if (first) begin
        // First beat restarts the counts instead of accumulating.
        total_coeff   <= 5'(nz);
        trailing_ones <= 2'(pm1);
        big_seen      <= big;
      end else begin
        total_coeff <= total_coeff + 5'(nz);
        if (!big_seen) begin
          if (pm1 && trailing_ones != 2'd3)
            trailing_ones <= trailing_ones + 2'd1;
          if (big)
            big_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cavlc_coeff_buf_ctrl.sv
// Sequences the 16-entry dual-port coefficient BRAM for one 4x4 block:
// writes 16 raster-order coefficients through port A, then streams them out
// of port B in reverse zig-zag order. The BRAM's registered read port acts as
// the output register; holding enb low freezes dob during a stall.
//   clk, rst                : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data      : raster-order coefficient input stream
//   out_valid/out_ready/out_data   : reverse zig-zag output stream (out_data = dob)
//   out_idx, out_last       : zig-zag position of out_data, marker for position 0
//   blk_done                : one-cycle pulse after the last output is accepted
//   ena/wea/addra/dia       : BRAM port A (write)
//   enb/addrb/dob           : BRAM port B (read, 1-cycle latency)
//   total_coeff/trailing_ones : block statistics when CAVLC_STATS_EN is defined,
//                               otherwise tied to 0
module cavlc_coeff_buf_ctrl
  import cavlc_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [3:0]            out_idx,
  output logic                  out_last,
  output logic                  blk_done,
  output logic                  ena,
  output logic                  wea,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [WIDTH-1:0]      dia,
  output logic                  enb,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [WIDTH-1:0]      dob,
  output logic [4:0]            total_coeff,
  output logic [1:0]            trailing_ones
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [3:0]            rd_cnt;
  logic                  accept;
  logic                  issue;

  assign in_ready = rst && (state == FILL);
  assign accept   = in_valid && in_ready;

  assign ena   = accept;
  assign wea   = accept;
  assign addra = wr_cnt;
  assign dia   = in_data;

  // A read may be issued whenever the output register is empty or is being
  // emptied this cycle; otherwise enb stays low so dob holds the stalled beat.
  assign issue = (state == DRAIN) && (!out_valid || out_ready);
  assign enb   = issue;
  assign addrb = ADDR_WIDTH'(ZZ_REV[rd_cnt]);

  assign out_data = dob;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      blk_done  <= 1'b0;
    end else begin
      blk_done <= 1'b0;
      unique case (state)
        FILL: begin
          if (accept) begin
            if (wr_cnt == ADDR_WIDTH'(BLK_SIZE - 1)) begin
              wr_cnt <= '0;
              state  <= DRAIN;
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (issue) begin
            out_valid <= 1'b1;
            out_idx   <= 4'd15 - rd_cnt;
            out_last  <= (rd_cnt == 4'd15);
            rd_cnt    <= rd_cnt + 1'b1;
            if (rd_cnt == 4'd15)
              state <= LAST;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        LAST: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              out_last <= 1'b0;
              blk_done <= 1'b1;
              rd_cnt   <= '0;
              state    <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

`ifdef CAVLC_STATS_EN
  cavlc_coeff_stats #(
    .WIDTH(WIDTH)
  ) u_stats (
    .clk          (clk),
    .rst          (rst),
    .acc          (out_valid && out_ready),
    .first        (out_idx == 4'd15),
    .data         (out_data),
    .total_coeff  (total_coeff),
    .trailing_ones(trailing_ones)
  );
`else
  assign total_coeff   = '0;
  assign trailing_ones = '0;
`endif

endmodule

// File: tb/tb_cavlc_coeff_buf_ctrl.sv
// Testbench for cavlc_coeff_buf_ctrl. A behavioural BRAM model sits on the
// A/B ports; expected output beats are queued once a block has been written
// and popped as the controller delivers them.
module tb_cavlc_coeff_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [8:0] out_data;
  logic [3:0] out_idx;
  logic       out_last;
  logic       blk_done;
  logic       ena, wea, enb;
  logic [3:0] addra, addrb;
  logic [8:0] dia;
  logic [8:0] dob;
  logic [4:0] total_coeff;
  logic [1:0] trailing_ones;

  always #5 clk = ~clk;

  cavlc_coeff_buf_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .blk_done(blk_done),
    .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .enb(enb), .addrb(addrb), .dob(dob),
    .total_coeff(total_coeff), .trailing_ones(trailing_ones)
  );

  // Dual-port BRAM model with registered read.
  logic [8:0] mem [16];
  always @(posedge clk) begin
    if (ena && wea) mem[addra] <= dia;
    if (enb) dob <= mem[addrb];
  end

  typedef struct {
    logic [8:0] data;
    logic [3:0] idx;
    logic       last;
  } beat_t;

  beat_t      sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         exp_tc, exp_t1;
  logic [8:0] blk [16];
  int         zz [16] = '{15, 14, 11, 7, 10, 13, 12, 9, 6, 3, 2, 5, 8, 4, 1, 0};

  // Writes blk[] into the DUT; optional idle cycles between beats. Starts and
  // ends 1 time unit after a rising edge. Queues the expected drain order.
  task automatic fill_block(input bit gap);
    int         i, cyc, big;
    logic [8:0] v;
    i = 0;
    cyc = 0;
    while (i < 16 && cyc < 200) begin
      if (gap && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
        in_data  = 9'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = blk[i];
      end
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_in_ready: got %b expected 1 at write %0d", in_ready, i);
      end
      n_checks++;
      if (in_valid && (ena !== 1'b1 || wea !== 1'b1 || addra !== 4'(i) || dia !== blk[i])) begin
        n_fail++;
        $display("FAIL fill_port_a: ena=%b wea=%b addra=%0d dia=%0d expected 1 1 %0d %0d",
                 ena, wea, addra, dia, i, blk[i]);
      end else if (!in_valid && ena !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_idle_ena: got %b expected 0", ena);
      end
      @(posedge clk);
      #1;
      if (in_valid) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (i < 16) begin
      n_fail++;
      $display("FAIL fill_timeout: accepted %0d expected 16", i);
    end
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || enb !== 1'b1 || addrb !== 4'd15 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL enter_drain: in_ready=%b enb=%b addrb=%0d out_valid=%b expected 0 1 15 0",
               in_ready, enb, addrb, out_valid);
    end
    exp_tc = 0;
    exp_t1 = 0;
    big = 0;
    for (int k = 0; k < 16; k++) begin
      v = blk[zz[k]];
      sb.push_back('{data: v, idx: 4'(15 - k), last: (k == 15)});
      if (v != 9'd0) exp_tc++;
      if (big == 0) begin
        if (v == 9'h001 || v == 9'h1FF) begin
          if (exp_t1 < 3) exp_t1++;
        end else if (v != 9'd0) begin
          big = 1;
        end
      end
    end
`ifndef CAVLC_STATS_EN
    exp_tc = 0;
    exp_t1 = 0;
`endif
  endtask

  // Accepts n output beats, comparing each with the scoreboard. With rnd set,
  // out_ready toggles randomly and stalled beats must hold.
  task automatic drain_block(input int n, input bit rnd, output int cycles);
    int         got;
    bit         stalled;
    logic [8:0] hold_data;
    logic [3:0] hold_idx;
    beat_t      b;
    got = 0;
    cycles = 0;
    stalled = 0;
    hold_data = '0;
    hold_idx = '0;
    while (got < n && cycles < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_in_ready: got %b expected 0", in_ready);
      end
      if (stalled) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== hold_data || out_idx !== hold_idx) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b data=%0d idx=%0d expected 1 %0d %0d",
                   out_valid, out_data, out_idx, hold_data, hold_idx);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: data=%0d idx=%0d with empty scoreboard", out_data, out_idx);
        end else begin
          b = sb.pop_front();
          if (out_data !== b.data || out_idx !== b.idx || out_last !== b.last) begin
            n_fail++;
            $display("FAIL drain_beat: data=%0d idx=%0d last=%b expected %0d %0d %b",
                     out_data, out_idx, out_last, b.data, b.idx, b.last);
          end
        end
        got++;
      end
      stalled   = (out_valid === 1'b1) && !out_ready;
      hold_data = out_data;
      hold_idx  = out_idx;
      cycles++;
      @(posedge clk);
      #1;
    end
    out_ready = 1'b0;
    if (got < n) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d beats expected %0d", got, n);
    end
  endtask

  // Called right after the last beat is accepted: blk_done pulse and stats.
  task automatic finish_block();
    n_checks++;
    if (blk_done !== 1'b1 || total_coeff !== 5'(exp_tc) || trailing_ones !== 2'(exp_t1)) begin
      n_fail++;
      $display("FAIL blk_done_stats: done=%b tc=%0d t1=%0d expected 1 %0d %0d",
               blk_done, total_coeff, trailing_ones, exp_tc, exp_t1);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (blk_done !== 1'b0 || in_ready !== 1'b1 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL blk_done_pulse: done=%b in_ready=%b left=%0d expected 0 1 0",
               blk_done, in_ready, sb.size());
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_idx !== 4'd0 || blk_done !== 1'b0 ||
        total_coeff !== 5'd0 || trailing_ones !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b last=%b idx=%0d done=%b tc=%0d t1=%0d expected all 0",
               out_valid, out_last, out_idx, blk_done, total_coeff, trailing_ones);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_raster_order();
    int cyc;
    for (int i = 0; i < 16; i++) blk[i] = 9'(i);
    fill_block(1'b0);
    drain_block(16, 1'b0, cyc);
    n_checks++;
    if (cyc != 17) begin
      n_fail++;
      $display("FAIL drain_cycles: got %0d expected 17", cyc);
    end
    finish_block();
  endtask

  task automatic test_random_ready();
    int cyc;
    for (int i = 0; i < 16; i++) blk[i] = 9'($urandom);
    fill_block(1'b0);
    drain_block(16, 1'b1, cyc);
    finish_block();
  endtask

  task automatic test_input_gaps();
    int cyc;
    for (int i = 0; i < 16; i++) blk[i] = 9'($urandom);
    fill_block(1'b1);
    drain_block(16, 1'b0, cyc);
    finish_block();
  endtask

  task automatic test_reset_mid_drain();
    int cyc;
    for (int i = 0; i < 16; i++) blk[i] = 9'($urandom);
    fill_block(1'b0);
    drain_block(5, 1'b0, cyc);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_idx !== 4'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_out: valid=%b idx=%0d last=%b expected 0 0 0",
               out_valid, out_idx, out_last);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || enb !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_release: in_ready=%b enb=%b expected 1 0", in_ready, enb);
    end
    sb.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) blk[i] = 9'(100 + i);
    fill_block(1'b0);
    drain_block(16, 1'b0, cyc);
    finish_block();
  endtask

  task automatic test_back_to_back();
    int cyc, prev_tc, prev_t1;
    for (int i = 0; i < 16; i++) blk[i] = 9'($urandom_range(0, 4)) - 9'd2;
    fill_block(1'b0);
    drain_block(16, 1'b1, cyc);
    finish_block();
    prev_tc = exp_tc;
    prev_t1 = exp_t1;
    for (int i = 0; i < 16; i++) blk[i] = 9'($urandom);
    n_checks++;
    if (total_coeff !== 5'(prev_tc) || trailing_ones !== 2'(prev_t1)) begin
      n_fail++;
      $display("FAIL stats_hold: tc=%0d t1=%0d expected %0d %0d",
               total_coeff, trailing_ones, prev_tc, prev_t1);
    end
    fill_block(1'b0);
    drain_block(16, 1'b0, cyc);
    finish_block();
  endtask

  task automatic test_stats();
    int cyc;
    int want_tc, want_t1;
    for (int i = 0; i < 16; i++) blk[i] = 9'd0;
    blk[1] = 9'd3;
    blk[2] = 9'h1FF;
    blk[5] = 9'h1FF;
    blk[6] = 9'd1;
    blk[8] = 9'd1;
`ifdef CAVLC_STATS_EN
    want_tc = 5;
    want_t1 = 3;
`else
    want_tc = 0;
    want_t1 = 0;
`endif
    fill_block(1'b0);
    drain_block(16, 1'b0, cyc);
    n_checks++;
    if (blk_done !== 1'b1 || total_coeff !== 5'(want_tc) || trailing_ones !== 2'(want_t1)) begin
      n_fail++;
      $display("FAIL stats_example: done=%b tc=%0d t1=%0d expected 1 %0d %0d",
               blk_done, total_coeff, trailing_ones, want_tc, want_t1);
    end
    finish_block();
  endtask

  initial begin
    test_reset();
    test_raster_order();
    test_random_ready();
    test_input_gaps();
    test_reset_mid_drain();
    test_back_to_back();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cavlc_coeff_buf_ctrl.md
Name: cavlc_coeff_buf_ctrl

Overview:
Controller that sequences the 16-entry, 9-bit dual-port coefficient BRAM for one 4x4 block.
- Accepts 16 raster-order coefficients from the transform/quant stage over a valid/ready stream and writes them through BRAM port A.
- Reads them back through port B in reverse zig-zag order as a valid/ready stream for the CAVLC encoder.
- Absorbs the 1-cycle BRAM read latency without a skid buffer, using enb as the output hold.

Parameters:
WIDTH, 9, coefficient width (signed two's complement)
ADDR_WIDTH, 4, BRAM address width; block size fixed at 16 entries

Ports:
clk  in  1  single clock; all logic posedge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  upstream coefficient valid
in_ready  out  1  controller accepts coefficient
in_data  in  WIDTH  coefficient, raster order 0..15
out_valid  out  1  out_data valid
out_ready  in  1  CAVLC encoder accepts
out_data  out  WIDTH  coefficient; wired directly from dob
out_idx  out  4  zig-zag position of out_data, 15 down to 0
out_last  out  1  marks zig-zag position 0
blk_done  out  1  1-cycle pulse after last coefficient is accepted
ena  out  1  BRAM port A enable
wea  out  1  BRAM port A write enable
addra  out  ADDR_WIDTH  BRAM write address
dia  out  WIDTH  BRAM write data
enb  out  1  BRAM port B enable
addrb  out  ADDR_WIDTH  BRAM read address
dob  in  WIDTH  BRAM read data, registered, 1-cycle latency
total_coeff  out  5  nonzero count (optional feature)
trailing_ones  out  2  trailing ±1 count (optional feature)

Behaviour:
- Reset (rst low, async):
  - state=FILL; wr_cnt=0, rd_cnt=0.
  - out_valid=0, out_last=0, out_idx=0, blk_done=0, total_coeff=0, trailing_ones=0.
  - in_ready=1 once rst is high.
- Reset mid-block discards the partial block. BRAM contents are don't-care because every block fully overwrites them.
- FILL state:
  - in_ready=1.
  - On in_valid&&in_ready: ena=wea=1, addra=wr_cnt, dia=in_data, then wr_cnt++.
  - When the write with wr_cnt==15 is accepted: wr_cnt<=0, go to DRAIN.
- DRAIN state:
  - in_ready=0.
  - Issue condition: can_issue = (!out_valid || out_ready) && rd_cnt<=15.
  - On issue: enb=1, addrb=ZZ_REV[rd_cnt], then rd_cnt++.
  - Next edge after an issue: out_valid<=1, out_idx<=15-rd_cnt(at issue), out_last<=(rd_cnt==15).
- ZZ_REV table (raster address per step, step 0..15): 15,14,11,7,10,13,12,9,6,3,2,5,8,4,1,0.
- Output stalls:
  - When out_valid&&!out_ready, enb=0, so dob, out_idx and out_last hold.
  - When out_valid&&out_ready with no new issue, out_valid<=0.
- Throughput: 1 coefficient/cycle with out_ready held high. First out_valid appears 1 cycle after entering DRAIN.
- After the step-15 issue, go to LAST. No further issues.
- LAST state: when out_valid&&out_ready&&out_last, blk_done<=1 for one cycle, rd_cnt<=0, go to FILL.
- Latency: last input accept to first out_valid = 2 cycles. A block is 16 fill cycles + 17 drain cycles minimum.
- No read/write collision: port A is idle in DRAIN/LAST and port B is idle in FILL. The first read (address 15) occurs one edge after its write.
- out_ready may be asserted while out_valid=0; it has no effect.
- Input data while in_ready=0 is ignored.

Optional Feature:
Macro CAVLC_STATS_EN.
- Defined:
  - Counters update on each accepted output coefficient.
  - total_coeff counts nonzero values (0..16).
  - trailing_ones counts ±1 values seen in reverse order before the first nonzero |value|>1, saturating at 3. Zeros are skipped.
  - Both are registered and valid in the blk_done cycle, held until the first accept of the next block, then cleared.
- Not defined: ports remain, tied to 0; no stats logic.

Decomposition:
- Package cavlc_pkg holds:
  - WIDTH and ADDR_WIDTH defaults;
  - BLK_SIZE=16;
  - the ZZ_REV constant array;
  - the state enum {FILL, DRAIN, LAST}.
- One sub-module, cavlc_coeff_stats, holds the optional counters. It is instantiated only under CAVLC_STATS_EN.
- The BRAM is instantiated by the parent, not inside this block.

Test Plan:
- Fill raster values 0..15 (in_data=i) with out_ready=1: out_data sequence 15,14,11,7,10,13,12,9,6,3,2,5,8,4,1,0; out_idx 15..0; out_last on the 16th beat; blk_done 1 cycle later.
- Random out_ready (50%) during drain: no duplicated or dropped values; out_data stable while stalled.
- in_valid gaps during FILL (every other cycle): wr_cnt advances only on accepts; transition to DRAIN occurs only after the 16th accept.
- Assert rst low mid-DRAIN after 5 outputs: out_valid=0 immediately, state=FILL, in_ready=1 after release; the next full block streams correctly.
- Two back-to-back blocks: in_ready=0 throughout drain; the second block's data is correct.
- CAVLC_STATS_EN defined, raster block {0,3,-1,0,0,-1,1,0,1,0,...0}: total_coeff=5, trailing_ones=3 at blk_done.
